dacc_core: RTL and testbench

Dual-accumulator execute stage of the double accumulator processor, directly downstream of the 6/8/10-to-16-bit sign extenders. It accepts one operation per handshake, takes a 16-bit sign-extended immediate or the other accumulator as operand, and updates accumulator A or B plus status flags. Single-cycle ALU ops complete on the accept edge. The optional multiply runs as a 16-cycle sequential shift-add.

---
 rtl/dacc_pkg.sv | 28 ++
 rtl/dacc_if.sv | 12 +
 rtl/dacc_mul_seq.sv | 56 +++++
 rtl/dacc_core.sv | 147 ++++++++++++++
 tb/tb_dacc_core.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dacc_pkg.sv
// dacc_pkg: shared width, opcodes, FSM states and flag layout for the dual-accumulator stage
package dacc_pkg;
  localparam int DACC_WIDTH = 16;
  localparam int DACC_MUL_CYCLES = DACC_WIDTH;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LD   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SWAP = 4'd7,
    OP_MUL  = 4'd8
  } dacc_op_e;
  typedef enum logic {S_IDLE, S_MUL} dacc_state_e;
  function automatic logic [3:0] mk_flags(input logic [DACC_WIDTH-1:0] r, input logic v, input logic c);
    mk_flags = '0;
    mk_flags[FLAG_Z] = r == '0;
    mk_flags[FLAG_N] = r[DACC_WIDTH-1];
    mk_flags[FLAG_V] = v;
    mk_flags[FLAG_C] = c;
  endfunction
endpackage

// File: rtl/dacc_if.sv
// dacc_if: operation request handshake from the sign-extender side into the execute stage
interface dacc_if;
  import dacc_pkg::*;
  logic                  op_valid;
  logic                  op_ready;
  logic [3:0]            op_code;
  logic                  op_dst;
  logic                  op_use_imm;
  logic [DACC_WIDTH-1:0] op_imm;
  modport master(output op_valid, op_code, op_dst, op_use_imm, op_imm, input op_ready);
  modport slave(input op_valid, op_code, op_dst, op_use_imm, op_imm, output op_ready);
endinterface

// File: rtl/dacc_mul_seq.sv
// dacc_mul_seq: signed sequential shift-add multiplier (sign-magnitude), result W cycles after start
module dacc_mul_seq
  import dacc_pkg::*;
#(
  parameter int W = DACC_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] prod,
  output logic         ovf
);
  localparam int CW = $clog2(W);
  localparam logic [2*W-1:0] half = (2*W)'(1) << (W-1);
  logic [W-1:0] a_mag, b_mag, mplier;
  logic [2*W-1:0] acc, mcand;
  logic neg;
  logic [CW-1:0] cnt;
  assign a_mag = a[W-1] ? -a : a;
  assign b_mag = b[W-1] ? -b : b;
  // bit 0 of the multiplier is folded into the load so W-1 shift steps finish in time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt <= '0;
      acc <= b_mag[0] ? {{W{1'b0}}, a_mag} : '0;
      mcand <= {{(W-1){1'b0}}, a_mag, 1'b0};
      mplier <= b_mag >> 1;
      neg <= a[W-1] ^ b[W-1];
    end else begin
      done <= busy && cnt == CW'(W-2);
      if (busy) begin
        acc <= mplier[0] ? acc + mcand : acc;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        busy <= cnt != CW'(W-2);
      end
    end
  end
  assign prod = neg ? -acc[W-1:0] : acc[W-1:0];
  assign ovf = neg ? acc > half : acc >= half;
endmodule

// File: rtl/dacc_core.sv
// dacc_core: dual-accumulator execute stage; define DACC_MUL_EN to build the 16-cycle multiplier
module dacc_core
  import dacc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  dacc_if.slave                 bus,
  output logic [DACC_WIDTH-1:0] acc_a,
  output logic [DACC_WIDTH-1:0] acc_b,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_v,
  output logic                  flag_c,
  output logic                  done,
  output logic                  err
);
  localparam int W = DACC_WIDTH;
  logic [3:0] flags;
  logic accept, legal, alu_go, wr_dst, wr_flags, swap, v, c;
  logic [W-1:0] dst_val, opnd, res;
  logic [W:0] sum;
`ifdef DACC_MUL_EN
  localparam int CW = $clog2(DACC_MUL_CYCLES);
  dacc_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic is_mul, mul_fin, mul_dst, mul_busy, mul_done, mul_ovf;
  logic [W-1:0] mul_prod;
`endif
  assign accept = bus.op_valid && bus.op_ready;
  assign dst_val = bus.op_dst ? acc_b : acc_a;
  assign opnd = bus.op_use_imm ? bus.op_imm : (bus.op_dst ? acc_a : acc_b);
  assign sum = {1'b0, dst_val} + {1'b0, opnd};
  always_comb begin
    res = opnd;
    v = 1'b0;
    c = flags[FLAG_C];
    legal = 1'b1;
    wr_dst = 1'b0;
    wr_flags = 1'b0;
    swap = 1'b0;
`ifdef DACC_MUL_EN
    is_mul = 1'b0;
`endif
    case (bus.op_code)
      OP_NOP: ;
      OP_LD: {wr_dst, wr_flags} = 2'b11;
      OP_ADD: begin
        {c, res} = sum;
        v = (dst_val[W-1] == opnd[W-1]) && (sum[W-1] != dst_val[W-1]);
        {wr_dst, wr_flags} = 2'b11;
      end
      OP_SUB: begin
        res = dst_val - opnd;
        c = dst_val >= opnd;
        v = (dst_val[W-1] != opnd[W-1]) && (res[W-1] != dst_val[W-1]);
        {wr_dst, wr_flags} = 2'b11;
      end
      OP_AND: begin
        res = dst_val & opnd;
        {wr_dst, wr_flags} = 2'b11;
      end
      OP_OR: begin
        res = dst_val | opnd;
        {wr_dst, wr_flags} = 2'b11;
      end
      OP_XOR: begin
        res = dst_val ^ opnd;
        {wr_dst, wr_flags} = 2'b11;
      end
      OP_SWAP: swap = 1'b1;
`ifdef DACC_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end
`ifdef DACC_MUL_EN
  assign alu_go = accept && legal && !is_mul;
  assign mul_fin = state == S_MUL && cnt == CW'(DACC_MUL_CYCLES - 1);
  assign bus.op_ready = state == S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      mul_dst <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == S_MUL ? cnt + 1'b1 : '0;
      mul_dst <= accept ? bus.op_dst : mul_dst;
    end
  end
  always_comb begin
    state_nx = state;
    if (state == S_IDLE && accept && is_mul) state_nx = S_MUL;
    else if (mul_fin) state_nx = S_IDLE;
  end
  dacc_mul_seq #(.W(W)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept && is_mul),
    .a    (dst_val),
    .b    (opnd),
    .busy (mul_busy),
    .done (mul_done),
    .prod (mul_prod),
    .ovf  (mul_ovf)
  );
  // the FSM counter and the multiplier run in lockstep from the same start
  always_ff @(posedge clk)
    if (rst_n) assert (mul_fin == mul_done && (state != S_MUL || mul_busy || mul_done));
`else
  assign alu_go = accept && legal;
  assign bus.op_ready = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_a <= '0;
      acc_b <= '0;
      flags <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= alu_go;
      err <= accept && !legal;
      if (alu_go && swap) begin
        acc_a <= acc_b;
        acc_b <= acc_a;
      end else if (alu_go && wr_dst) begin
        if (bus.op_dst) acc_b <= res;
        else acc_a <= res;
      end
      if (alu_go && wr_flags) flags <= mk_flags(res, v, c);
`ifdef DACC_MUL_EN
      if (mul_fin) begin
        if (mul_dst) acc_b <= mul_prod;
        else acc_a <= mul_prod;
        flags <= mk_flags(mul_prod, mul_ovf, 1'b0);
        done <= 1'b1;
      end
`endif
    end
  end
  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];
  assign flag_c = flags[FLAG_C];
endmodule

// File: tb/tb_dacc_core.sv
// tb_dacc_core: randomized scoreboard bench for dacc_core against a behavioural model
module tb_dacc_core;
  import dacc_pkg::*;
  localparam int W = DACC_WIDTH;
  localparam int smax = (1 << (W - 1)) - 1;
  localparam int smin = -(1 << (W - 1));
  typedef struct {
    int cyc;
    bit e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0] f;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] acc_a, acc_b;
  logic flag_z, flag_n, flag_v, flag_c, done, err;
  dacc_if bus();
  dacc_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .acc_a (acc_a),
    .acc_b (acc_b),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_v(flag_v),
    .flag_c(flag_c),
    .done  (done),
    .err   (err)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  exp_t got;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mul_acc = -100;
  bit quiet = 1'b1;
  logic [W-1:0] ma = '0, mb = '0;
  logic [3:0] mf = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference model: flags kept as {z, n, v, c}
  task automatic predict(input logic [3:0] c, input logic d, input logic u, input logic [W-1:0] im, input int at);
    logic [W-1:0] dv, ov, r;
    int s;
    bit wr, fl, v, e, cf;
    int lat;
    wr = 0; fl = 0; v = 0; e = 0; lat = 1;
    dv = d ? mb : ma;
    ov = u ? im : (d ? ma : mb);
    cf = mf[0];
    r = ov;
    case (c)
      4'd0: ;
      4'd1: begin wr = 1; fl = 1; end
      4'd2: begin
        s = int'(dv) + int'(ov);
        r = s[W-1:0];
        cf = s >= (1 << W);
        s = int'($signed(dv)) + int'($signed(ov));
        v = s > smax || s < smin;
        wr = 1; fl = 1;
      end
      4'd3: begin
        s = int'($signed(dv)) - int'($signed(ov));
        r = s[W-1:0];
        cf = dv >= ov;
        v = s > smax || s < smin;
        wr = 1; fl = 1;
      end
      4'd4: begin r = dv & ov; wr = 1; fl = 1; end
      4'd5: begin r = dv | ov; wr = 1; fl = 1; end
      4'd6: begin r = dv ^ ov; wr = 1; fl = 1; end
      4'd7: begin r = ma; ma = mb; mb = r; end
`ifdef DACC_MUL_EN
      4'd8: begin
        s = int'($signed(dv)) * int'($signed(ov));
        r = s[W-1:0];
        v = s > smax || s < smin;
        cf = 0;
        wr = 1; fl = 1;
        lat = 1 + W;
        mul_acc = at;
      end
`endif
      default: e = 1;
    endcase
    if (wr) begin
      if (d) mb = r;
      else ma = r;
    end
    if (fl) mf = {r == '0, r[W-1], v, cf};
    sb.push_back('{at + lat, e, ma, mb, mf});
  endtask
  task automatic issue(input logic [3:0] c, input logic d, input logic u, input logic [W-1:0] im);
    int n;
    n = 0;
    bus.op_valid = 1'b1;
    bus.op_code = c;
    bus.op_dst = d;
    bus.op_use_imm = u;
    bus.op_imm = im;
    while (!bus.op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.op_ready) predict(c, d, u, im, cyc);
    else check("accept_timeout", bus.op_ready, 1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_imm = W'($urandom);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask
  task automatic expect_state(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    check({name, "_a"}, acc_a, a);
    check({name, "_b"}, acc_b, b);
    check({name, "_flags"}, {flag_z, flag_n, flag_v, flag_c}, f);
  endtask
  task automatic do_reset(input int n);
    quiet = 1'b1;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    mul_acc = -100;
    ma = '0;
    mb = '0;
    mf = '0;
    expect_state("rst", '0, '0, 4'b0000);
    check("rst_ready", bus.op_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    quiet = 1'b0;
  endtask
  function automatic logic [W-1:0] pick_imm();
    int k;
    k = $urandom_range(0, 6);
    return k == 0 ? W'(smax) : k == 1 ? W'(1 << (W - 1)) : k == 2 ? '0 : k == 3 ? '1 : W'($urandom);
  endfunction
  always begin
    @(negedge clk);
    #1;
    if (!quiet) begin
      check("ready", bus.op_ready, !(cyc > mul_acc && cyc <= mul_acc + W));
      check("done_err_overlap", done & err, 0);
      if (done || err) begin
        check("retire_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("retire_cycle", cyc, got.cyc);
          check("err", err, got.e);
          check("done", done, !got.e);
          check("acc_a", acc_a, got.a);
          check("acc_b", acc_b, got.b);
          check("flags", {flag_z, flag_n, flag_v, flag_c}, got.f);
        end
      end
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1);
  end
  initial begin
    bus.op_valid = 1'b0;
    bus.op_code = '0;
    bus.op_dst = 1'b0;
    bus.op_use_imm = 1'b0;
    bus.op_imm = '0;
    @(negedge clk);
    do_reset(2);
    issue(4'd1, 0, 1, 16'hFFFF);
    drain();
    expect_state("ld_neg", 16'hFFFF, 16'h0000, 4'b0100);
    issue(4'd2, 0, 1, 16'h0001);
    drain();
    expect_state("add_carry", 16'h0000, 16'h0000, 4'b1001);
    issue(4'd1, 0, 1, 16'h7FFF);
    issue(4'd2, 0, 1, 16'h0001);
    drain();
    expect_state("add_ovf", 16'h8000, 16'h0000, 4'b0110);
    issue(4'd1, 0, 1, 16'h0005);
    issue(4'd1, 1, 1, 16'h0009);
    issue(4'd7, 1, 1, 16'h1234);
    drain();
    expect_state("swap", 16'h0009, 16'h0005, 4'b0000);
    issue(4'd3, 1, 0, 16'hAAAA);
    drain();
    expect_state("sub_borrow", 16'h0009, 16'hFFFC, 4'b0100);
    issue(4'd15, 0, 1, 16'h0000);
`ifndef DACC_MUL_EN
    issue(4'd8, 0, 0, 16'h0003);
`endif
    drain();
    expect_state("illegal", 16'h0009, 16'hFFFC, 4'b0100);
`ifdef DACC_MUL_EN
    issue(4'd1, 0, 1, 16'hFFFD);
    issue(4'd1, 1, 1, 16'h0007);
    issue(4'd8, 0, 0, 16'h0000);
    issue(4'd2, 0, 1, 16'h0001);
    drain();
    expect_state("mul_then_add", 16'hFFEC, 16'h0007, 4'b0100);
    issue(4'd8, 0, 1, 16'h0003);
`else
    issue(4'd2, 0, 1, 16'h0003);
`endif
    repeat (7) @(negedge clk);
    do_reset(1);
    issue(4'd1, 0, 1, 16'h1234);
    drain();
    expect_state("ld_after_rst", 16'h1234, 16'h0000, 4'b0000);
    for (int i = 0; i < 400; i++) begin
      int pk;
      logic [3:0] c;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pk = $urandom_range(0, 19);
      c = pk < 16 ? 4'(pk % 9) : 4'($urandom_range(9, 15));
      issue(c, 1'($urandom), 1'($urandom), pick_imm());
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
